seg7_scan_decoder: RTL and testbench

// - Receive side of the 7-segment display interface: samples active-low segment lines and

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_pattern_decode.sv | 27 ++
 rtl/seg7_scan_decoder.sv | 148 ++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment patterns, code constants and FSM state type for the 7-segment receiver
package seg7_pkg;

  // Active-low segment patterns, bit0=A .. bit6=G
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_BLANK   = 4'hF;
  localparam logic [3:0] CODE_INVALID = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational segment pattern to 4-bit code lookup
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] code
);

  // Unknown patterns map to the invalid code so the caller can flag them
  always_comb begin
    case (pattern)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      default:   code = CODE_INVALID;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - recovers stable digit frames from a multiplexed 7-segment display
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    frame_valid,
  output logic                    digit_err,
  output logic                    ghost_err,
  output logic                    frame_timeout
);

  localparam int CW  = $clog2(STABLE_CYCLES + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES);
  localparam int KW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int NZW = $clog2(NUM_DIGITS + 1);

  logic [6:0]              seg_s1, seg_s2;
  logic [NUM_DIGITS-1:0]   an_s1, an_s2;
  logic [NZW-1:0]          nzero;
  logic [KW-1:0]           samp_k;
  logic                    samp_digit, samp_ghost;
  logic [3:0]              samp_code;
  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [KW-1:0]           cur_k;
  logic [6:0]              cur_seg;
  logic                    same, restart, wr_en;
  logic [NUM_DIGITS-1:0]   mask, mask_next;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_next;
  logic [TW-1:0]           tcnt;
  logic                    frame_done, tmo_hit;

  // Two-flop synchroniser; idle (all ones) out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s1 <= '1;
      seg_s2 <= '1;
      an_s1  <= '1;
      an_s2  <= '1;
    end else begin
      seg_s1 <= seg;
      seg_s2 <= seg_s1;
      an_s1  <= an;
      an_s2  <= an_s1;
    end
  end

  // Classify the anode sample: none low, exactly one low, or several low
  always_comb begin
    nzero  = '0;
    samp_k = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_s2[i]) begin
        nzero  = nzero + NZW'(1);
        samp_k = KW'(i);
      end
    end
    samp_digit = (nzero == NZW'(1));
    samp_ghost = (nzero > NZW'(1));
  end

  seg7_pattern_decode u_decode (
    .pattern (seg_s2),
    .code    (samp_code)
  );

  // Tracking decisions, pending mask and shadow update for this cycle
  always_comb begin
    same       = samp_digit && (samp_k == cur_k) && (seg_s2 == cur_seg);
    restart    = (state == ST_IDLE) || !same;
    wr_en      = (state == ST_TRACK) && same && (cnt == CW'(STABLE_CYCLES - 1));
    shadow_next = shadow;
    if (wr_en) shadow_next[{cur_k, 2'b00} +: 4] = samp_code;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      mask_next[i] = mask[i] | (wr_en && (cur_k == KW'(i)));
    end
    frame_done = &mask_next;
    tmo_hit    = (mask != '0) && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  end

  // Per-digit stability FSM: any change of sample re-enters as if from idle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cur_k     <= '0;
      cur_seg   <= '1;
      ghost_err <= 1'b0;
    end else begin
      ghost_err <= 1'b0;
      if (restart) begin
        if (samp_digit) begin
          state   <= ST_TRACK;
          cnt     <= CW'(1);
          cur_k   <= samp_k;
          cur_seg <= seg_s2;
        end else begin
          state     <= ST_IDLE;
          cnt       <= '0;
          ghost_err <= samp_ghost;
        end
      end else if (state == ST_TRACK) begin
        if (cnt != CW'(STABLE_CYCLES)) cnt <= cnt + CW'(1);
        if (wr_en) state <= ST_LOCKED;
      end
    end
  end

  // Frame assembly: completion beats timeout, timeout discards the partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      mask          <= '0;
      tcnt          <= '0;
      shadow        <= {NUM_DIGITS{CODE_BLANK}};
      digits        <= {NUM_DIGITS{CODE_BLANK}};
      frame_valid   <= 1'b0;
      digit_err     <= 1'b0;
      frame_timeout <= 1'b0;
    end else begin
      digit_err     <= wr_en && (samp_code == CODE_INVALID);
      frame_valid   <= 1'b0;
      frame_timeout <= 1'b0;
      shadow        <= shadow_next;
      if (frame_done) begin
        digits      <= shadow_next;
        frame_valid <= 1'b1;
        mask        <= '0;
        tcnt        <= '0;
      end else if (tmo_hit) begin
        frame_timeout <= 1'b1;
        mask          <= '0;
        tcnt          <= '0;
      end else begin
        mask <= mask_next;
        tcnt <= (mask != '0) ? tcnt + TW'(1) : '0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - self-checking bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic        frame_valid, digit_err, ghost_err, frame_timeout;

  int errors = 0;
  int checks = 0;
  int frames = 0;
  int ghosts = 0;
  int derrs  = 0;
  int tmos   = 0;
  logic [15:0] sb[$];

  typedef struct {
    logic [3:0]  d0, d1, d2, d3;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[4];

  seg7_scan_decoder #(
    .NUM_DIGITS     (4),
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .seg           (seg),
    .an            (an),
    .digits        (digits),
    .frame_valid   (frame_valid),
    .digit_err     (digit_err),
    .ghost_err     (ghost_err),
    .frame_timeout (frame_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0011000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic [3:0] an_v, input logic [6:0] seg_v, input int n);
    #1;
    an  = an_v;
    seg = seg_v;
    repeat (n) @(posedge clk);
  endtask

  task automatic idle(input int n);
    hold(4'b1111, 7'b1111111, n);
  endtask

  task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
    hold(4'b1110, s0, 8);
    hold(4'b1101, s1, 8);
    hold(4'b1011, s2, 8);
    hold(4'b0111, s3, 8);
    idle(6);
  endtask

  // Scoreboard side: compare each completed frame and count error pulses
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid) begin
        frames++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL frame_unexpected actual=%h expected=none", digits);
        end else begin
          logic [15:0] e;
          e = sb.pop_front();
          if (digits !== e) begin
            errors++;
            $display("FAIL frame_digits actual=%h expected=%h", digits, e);
          end
        end
      end
      if (ghost_err) ghosts++;
      if (digit_err) derrs++;
      if (frame_timeout) tmos++;
    end
  end

  initial begin
    int f0, g0, d0, t0;

    vecs[0] = '{d0: 4'd1, d1: 4'd2, d2: 4'd3, d3: 4'd4, exp: 16'h4321};
    vecs[1] = '{d0: 4'd9, d1: 4'd8, d2: 4'd7, d3: 4'd6, exp: 16'h6789};
    vecs[2] = '{d0: 4'd0, d1: 4'd5, d2: 4'hF, d3: 4'd3, exp: 16'h3F50};
    vecs[3] = '{d0: 4'd8, d1: 4'd0, d2: 4'd0, d3: 4'd8, exp: 16'h8008};

    rst = 1'b1;
    an  = 4'b1111;
    seg = 7'b1111111;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_digits", digits, 16'hFFFF);
    check("reset_frame_valid", frame_valid, 0);
    check("reset_digit_err", digit_err, 0);
    check("reset_ghost_err", ghost_err, 0);
    check("reset_frame_timeout", frame_timeout, 0);
    @(posedge clk);

    f0 = frames;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(vecs[i].exp);
      scan4(pat(vecs[i].d0), pat(vecs[i].d1), pat(vecs[i].d2), pat(vecs[i].d3));
    end
    check("table_frame_count", frames - f0, 4);
    check("table_no_digit_err", derrs, 0);
    check("table_no_ghost_err", ghosts, 0);

    // Digit 0 held only 3 cycles must not be accepted
    f0 = frames;
    sb.push_back(16'h4325);
    hold(4'b1110, pat(4'd7), 3);
    hold(4'b1101, pat(4'd2), 8);
    hold(4'b1011, pat(4'd3), 8);
    hold(4'b0111, pat(4'd4), 8);
    idle(6);
    check("short_hold_no_frame", frames - f0, 0);
    hold(4'b1110, pat(4'd5), 8);
    idle(6);
    check("short_hold_frame_after_d0", frames - f0, 1);

    // Ghost mid-scan resets tracking: 3+3 cycles around it is not enough
    f0 = frames;
    g0 = ghosts;
    sb.push_back(16'h9876);
    hold(4'b1110, pat(4'd6), 8);
    hold(4'b1101, pat(4'd7), 3);
    hold(4'b1100, pat(4'd7), 1);
    hold(4'b1101, pat(4'd7), 3);
    hold(4'b1011, pat(4'd8), 8);
    hold(4'b0111, pat(4'd9), 8);
    idle(6);
    check("ghost_pulse_count", ghosts - g0, 1);
    check("ghost_no_frame", frames - f0, 0);
    hold(4'b1101, pat(4'd7), 8);
    idle(6);
    check("ghost_frame_after_d1", frames - f0, 1);

    // Invalid pattern is flagged and still stored
    f0 = frames;
    d0 = derrs;
    sb.push_back(16'h321E);
    scan4(7'b0101010, pat(4'd1), pat(4'd2), pat(4'd3));
    check("invalid_digit_err", derrs - d0, 1);
    check("invalid_frame_count", frames - f0, 1);

    // Only digits 0-2 scanned: one timeout, output frame untouched
    f0 = frames;
    t0 = tmos;
    for (int r = 0; r < 3; r++) begin
      hold(4'b1110, pat(4'd1), 8);
      hold(4'b1101, pat(4'd1), 8);
      hold(4'b1011, pat(4'd1), 8);
    end
    idle(8);
    check("timeout_count", tmos - t0, 1);
    check("timeout_no_frame", frames - f0, 0);
    @(negedge clk);
    check("timeout_digits_kept", digits, 16'h321E);

    // Reset after two accepted digits discards the partial frame
    hold(4'b1110, pat(4'd5), 8);
    hold(4'b1101, pat(4'd6), 8);
    #1 rst = 1'b1;
    an  = 4'b1111;
    seg = 7'b1111111;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_digits", digits, 16'hFFFF);
    check("rst_mid_frame_valid", frame_valid, 0);
    check("rst_mid_digit_err", digit_err, 0);
    check("rst_mid_ghost_err", ghost_err, 0);
    check("rst_mid_frame_timeout", frame_timeout, 0);
    f0 = frames;
    sb.push_back(16'h8765);
    hold(4'b1011, pat(4'd7), 8);
    hold(4'b0111, pat(4'd8), 8);
    idle(6);
    check("rst_mask_cleared", frames - f0, 0);
    hold(4'b1110, pat(4'd5), 8);
    hold(4'b1101, pat(4'd6), 8);
    idle(6);
    check("rst_fresh_frame", frames - f0, 1);

    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
